alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream command stage for the combinational alu_4bit.
- Accepts ALU commands over a valid/ready handshake and buffers them in a 4-deep FIFO.
- Reads operands from a 4x4-bit register file and drives A/B/sel into alu_4bit.
- Writes the ALU result back to the register file and reports each completion on a one-cycle done pulse.

Parameters:
DATA_W  4  operand/result width, matches alu_4bit
SEL_W   3  ALU opcode width
DEPTH   4  command FIFO depth (power of two)
NREG    4  register-file entries; index width = log2(NREG) = 2

Ports:
clk        in   1       single clock, rising edge
rst        in   1       reset, synchronous, active-high
cmd_valid  in   1       command offered
cmd_ready  out  1       FIFO can accept
cmd_sel    in   3       ALU opcode, passed through unchanged
cmd_src_a  in   2       reg index for ALU A
cmd_src_b  in   2       reg index for ALU B
cmd_dst    in   2       reg index for result
wr_en      in   1       host register write
wr_addr    in   2       host write index
wr_data    in   4       host write data
alu_a      out  4       to alu_4bit.A (registered)
alu_b      out  4       to alu_4bit.B (registered)
alu_sel    out  3       to alu_4bit.sel (registered)
alu_result in   4       from alu_4bit.result
done_valid out  1       one-cycle completion pulse
done_dst   out  2       completed destination index
done_data  out  4       completed result
busy       out  1       state!=IDLE or FIFO non-empty
fifo_count out  3       entries held, 0..4

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - Register file all 0; FIFO empty; fifo_count 0; state IDLE.
  - alu_a, alu_b, alu_sel, done_valid, done_dst and done_data all 0.
  - cmd_ready is 0 while rst is high. Pushes and wr_en are ignored during reset.
- Reset mid-operation: FIFO contents and the in-flight command are discarded. No done pulse is emitted for them.
- Handshake: push on cmd_valid && cmd_ready. cmd_ready = !rst && fifo_count<DEPTH.
  - When full, cmd_ready is 0 even if a pop happens in the same cycle. No push-through.
  - Commands are held stable by the producer until accepted. Order is strictly FIFO.
- FSM:
  - IDLE: if FIFO non-empty, pop the head and register alu_a<=regs[src_a], alu_b<=regs[src_b], alu_sel<=sel, dst_q<=dst. Go to EXEC.
  - EXEC: alu_result is valid combinationally. At the edge: regs[dst_q]<=alu_result, done_valid<=1, done_dst<=dst_q, done_data<=alu_result. Go to WB.
  - WB: done_valid is high for this cycle only. If FIFO non-empty, pop and load operands as in IDLE, then go to EXEC. Otherwise go to IDLE.
- Latency and throughput:
  - A push into an empty idle block at edge N gives the pop at edge N+1, writeback at edge N+2, and done_valid high during the cycle after N+2.
  - Sustained throughput is one command per 2 cycles.
- Hazards:
  - Operands are read from pre-edge register values. A pop in WB therefore sees the previous command's writeback, so RAW between consecutive commands is safe.
  - Host wr_en to the same index as the EXEC writeback on the same edge: writeback wins.
  - A host write on the same edge as an operand read: the read gets the old value.
- Width rules: all arithmetic lives in alu_4bit. The result is taken as 4 bits, so overflow wraps modulo 16. Opcodes 101–111 are passed through and the ALU's output is written back.
- fifo_count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.

Decomposition:
- Package alu_seq_pkg:
  - Constants DATA_W, SEL_W, REG_IDX_W.
  - State encoding IDLE/EXEC/WB.
  - ALU opcode constants: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100.
  - Packed command struct {sel, src_a, src_b, dst} (9 bits).
- One sub-module, sync_fifo:
  - Parameterised width and depth, with wrapping read/write pointers, count, full and empty.
  - Instantiated for the command queue.
- Register file and FSM stay in the top level.

Test Plan:
- Reset then host write r0=5, r1=3. Push {ADD,0,1,2} → done_valid 3 cycles after the push edge, done_dst=2, done_data=8, regs[2]=8.
- Push {SUB,0,1,3} with r0=5, r1=3 → done_data=2. Set r0=F, r1=1 and push {ADD,0,1,2} → done_data=0 (wrap).
- RAW back-to-back: with r0=5, r1=3, push {ADD,0,1,2} then {OR,2,1,3} on consecutive cycles → done pulses 2 cycles apart; data 8 then B; regs[3]=B.
- Full FIFO: push 10 commands with cmd_valid held high → cmd_ready drops when fifo_count=4. All 10 done pulses arrive in push order, exactly 2 cycles apart, with none lost or duplicated.
- Collision: host wr_en to r2 with data 7 on the same edge as the EXEC writeback of 8 to r2 → regs[2]=8.
- Assert rst for 1 cycle while in EXEC with 3 queued → no done pulse, fifo_count=0, outputs 0, cmd_ready=1 in the cycle after rst falls.

Source files
------------

// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_seq_pkg
// Description : Shared constants, state encoding and command format for the
//               ALU command sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam int DATA_W    = 4;
  localparam int SEL_W     = 3;
  localparam int NREG      = 4;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b100;

  typedef struct packed {
    logic [SEL_W-1:0]     sel;
    logic [REG_IDX_W-1:0] src_a;
    logic [REG_IDX_W-1:0] src_b;
    logic [REG_IDX_W-1:0] dst;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer_sync_fifo.sv
//------------------------------------------------------------------------------
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through read data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !rst;
  assign w_do_pop  = pop && !empty && !rst;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_cmd_sequencer
// Description : Queues ALU commands, fetches operands from a small register
//               file, drives alu_4bit and writes its result back.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic [REG_IDX_W-1:0]      cmd_src_a,
  input  logic [REG_IDX_W-1:0]      cmd_src_b,
  input  logic [REG_IDX_W-1:0]      cmd_dst,
  input  logic                      wr_en,
  input  logic [REG_IDX_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_sel,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      done_valid,
  output logic [REG_IDX_W-1:0]      done_dst,
  output logic [DATA_W-1:0]         done_data,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  cmd_t                  w_cmd_in;
  cmd_t                  w_cmd_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  state_t                r_state;
  logic [DATA_W-1:0]     r_regs [NREG];
  logic [REG_IDX_W-1:0]  r_dst_q;

  assign w_cmd_in = '{sel: cmd_sel, src_a: cmd_src_a, src_b: cmd_src_b, dst: cmd_dst};

  // Full blocks a push even when a pop frees a slot on the same edge
  assign cmd_ready = !rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !rst && !w_empty && ((r_state == IDLE) || (r_state == WB));
  assign busy      = (r_state != IDLE) || !w_empty;

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_cmd_in),
    .pop   (w_pop),
    .rdata (w_cmd_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dst_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      done_valid <= 1'b0;
      done_dst   <= '0;
      done_data  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      done_valid <= 1'b0;
      if (wr_en) r_regs[wr_addr] <= wr_data;
      case (r_state)
        IDLE, WB: begin
          // Operand reads see pre-edge register contents
          if (w_pop) begin
            alu_a   <= r_regs[w_cmd_head.src_a];
            alu_b   <= r_regs[w_cmd_head.src_b];
            alu_sel <= w_cmd_head.sel;
            r_dst_q <= w_cmd_head.dst;
            r_state <= EXEC;
          end else begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          // Later assignment overrides a same-index host write
          r_regs[r_dst_q] <= alu_result;
          done_valid      <= 1'b1;
          done_dst        <= r_dst_q;
          done_data       <= alu_result;
          r_state         <= WB;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench with a behavioural alu_4bit and a
//               scoreboard of expected completions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic [1:0] cmd_src_a = '0;
  logic [1:0] cmd_src_b = '0;
  logic [1:0] cmd_dst = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       done_valid;
  logic [1:0] done_dst;
  logic [3:0] done_data;
  logic       busy;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [1:0] dst;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] regs_m [4];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_done = -1;
  bit         chk_gap = 1'b0;
  bit         saw_full = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[2:0], 1'b0};
      default: return a + 4'd1;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_a, alu_b);

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .done_valid (done_valid),
    .done_dst   (done_dst),
    .done_data  (done_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done pulse must match the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #2;
    if (done_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", {7'd0, done_valid}, 8'd0);
      end else begin
        e = sb.pop_front();
        check("done_dst", {6'd0, done_dst}, {6'd0, e.dst});
        check("done_data", {4'd0, done_data}, {4'd0, e.data});
      end
      if (chk_gap && last_done >= 0) check("done_gap", 8'(cyc - last_done), 8'd2);
      last_done = cyc;
    end
  end

  task automatic host_write(input logic [1:0] a, input logic [3:0] d, input bit model);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (model) regs_m[a] = d;
  endtask

  // Returns 1 ns after the edge on which the command was accepted
  task automatic push_cmd(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
    exp_t e;
    int   n = 0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    while (cmd_ready !== 1'b1 && n < 50) begin
      check("ready_vs_count", {7'd0, cmd_ready}, {7'd0, (fifo_count != 3'd4)});
      if (fifo_count === 3'd4) saw_full = 1'b1;
      step();
      n++;
    end
    if (n >= 50) check("push_timeout", {7'd0, cmd_ready}, 8'd1);
    e.data = alu_f(s, regs_m[a], regs_m[b]);
    e.dst  = d;
    regs_m[d] = e.data;
    sb.push_back(e);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("idle_reached", {7'd0, busy}, 8'd0);
    step();
    check("sb_drained", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) regs_m[i] = 4'd0;

    // Reset with a command offered and a host write attempted
    rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 3'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF;
    step();
    step();
    check("rst_ready", {7'd0, cmd_ready}, 8'd0);
    check("rst_count", {5'd0, fifo_count}, 8'd0);
    cmd_valid = 1'b0; wr_en = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_ready", {7'd0, cmd_ready}, 8'd1);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check("post_rst_alu", {1'b0, alu_sel, alu_a}, 8'd0);
    check("post_rst_alub", {4'd0, alu_b}, 8'd0);
    check("post_rst_done", {1'b0, done_valid, done_dst, done_data}, 8'd0);
    check("post_rst_r0", {4'd0, dut.r_regs[0]}, 8'd0);
    step();

    // Basic ADD with latency checks
    host_write(2'd0, 4'd5, 1'b1);
    host_write(2'd1, 4'd3, 1'b1);
    push_cmd(3'd0, 2'd0, 2'd1, 2'd2);
    check("lat_n_done", {7'd0, done_valid}, 8'd0);
    check("lat_n_count", {5'd0, fifo_count}, 8'd1);
    step();
    check("lat_n1_done", {7'd0, done_valid}, 8'd0);
    check("lat_n1_a", {4'd0, alu_a}, 8'd5);
    check("lat_n1_b", {4'd0, alu_b}, 8'd3);
    check("lat_n1_sel", {5'd0, alu_sel}, 8'd0);
    step();
    check("lat_n2_done", {7'd0, done_valid}, 8'd1);
    wait_idle();
    check("add_r2", {4'd0, dut.r_regs[2]}, 8'd8);

    // SUB, then ADD that wraps
    push_cmd(3'd1, 2'd0, 2'd1, 2'd3);
    wait_idle();
    host_write(2'd0, 4'hF, 1'b1);
    host_write(2'd1, 4'h1, 1'b1);
    push_cmd(3'd0, 2'd0, 2'd1, 2'd2);
    wait_idle();
    check("wrap_r2", {4'd0, dut.r_regs[2]}, 8'd0);

    // RAW between back-to-back commands
    host_write(2'd0, 4'd5, 1'b1);
    host_write(2'd1, 4'd3, 1'b1);
    chk_gap = 1'b1; last_done = -1;
    push_cmd(3'd0, 2'd0, 2'd1, 2'd2);
    push_cmd(3'd3, 2'd2, 2'd1, 2'd3);
    wait_idle();
    chk_gap = 1'b0;
    check("raw_r3", {4'd0, dut.r_regs[3]}, 8'hB);

    // Ten back-to-back commands overflow the FIFO
    last_done = -1; chk_gap = 1'b1; saw_full = 1'b0;
    push_cmd(3'd0, 2'd0, 2'd1, 2'd2);
    push_cmd(3'd1, 2'd2, 2'd1, 2'd3);
    push_cmd(3'd2, 2'd3, 2'd0, 2'd0);
    push_cmd(3'd3, 2'd1, 2'd2, 2'd1);
    push_cmd(3'd4, 2'd0, 2'd3, 2'd2);
    push_cmd(3'd5, 2'd2, 2'd0, 2'd3);
    push_cmd(3'd6, 2'd3, 2'd1, 2'd0);
    push_cmd(3'd7, 2'd0, 2'd0, 2'd1);
    push_cmd(3'd0, 2'd1, 2'd1, 2'd2);
    push_cmd(3'd1, 2'd3, 2'd2, 2'd3);
    wait_idle();
    chk_gap = 1'b0;
    check("saw_full", {7'd0, saw_full}, 8'd1);
    for (int i = 0; i < 4; i++) check("burst_regs", {4'd0, dut.r_regs[i]}, {4'd0, regs_m[i]});

    // Host write colliding with writeback to the same register
    host_write(2'd0, 4'd5, 1'b1);
    host_write(2'd1, 4'd3, 1'b1);
    push_cmd(3'd0, 2'd0, 2'd1, 2'd2);
    step();
    host_write(2'd2, 4'd7, 1'b0);
    wait_idle();
    check("collide_r2", {4'd0, dut.r_regs[2]}, 8'd8);

    // Reset while executing with three commands queued
    begin
      int n = 0;
      while (!(fifo_count === 3'd3 && done_valid === 1'b0 && busy === 1'b1) && n < 8) begin
        push_cmd(3'd0, 2'd0, 2'd1, 2'(n));
        n++;
      end
      check("mid_rst_setup", {5'd0, fifo_count}, 8'd3);
    end
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) regs_m[i] = 4'd0;
    step();
    check("mid_rst_ready", {7'd0, cmd_ready}, 8'd0);
    rst = 1'b0;
    step();
    check("mid_rst_count", {5'd0, fifo_count}, 8'd0);
    check("mid_rst_done", {7'd0, done_valid}, 8'd0);
    check("mid_rst_alu", {1'b0, alu_sel, alu_a}, 8'd0);
    check("mid_rst_ready1", {7'd0, cmd_ready}, 8'd1);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_r2", {4'd0, dut.r_regs[2]}, 8'd0);
    for (int i = 0; i < 4; i++) step();
    check("mid_rst_quiet", {7'd0, busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
